// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around a single
// gate-level full adder. Operands are captured on an accepted start, one
// bit is processed per clock LSB first, and a one-cycle done pulse marks
// the result as valid. Optional build macro SERIAL_SUB_EN enables
// two's-complement subtraction when sub=1 is captured with the operands.

// Gate-level 1-bit full adder shared by every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ c;
  assign co  = (a & b) | (c & axb);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             fa_s;
  logic             fa_co;

  // Subtraction folds into the load: B is stored inverted and the initial
  // carry forced to 1, so the bit-step datapath is identical in both builds.
`ifdef SERIAL_SUB_EN
  assign b_eff = sub ? ~b_in : b_in;
  assign c_eff = sub | cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_eff      = b_in;
  assign c_eff      = cin;
`endif

  assign last = (cnt == CNT_LAST);

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register; reset wins over everything, including mid-RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; start is only honoured in IDLE/DONE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on load, one shift/add per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      op_a  <= a_in;
      op_b  <= b_eff;
      carry <= c_eff;
      cnt   <= '0;
      sum   <= '0;
    end else if (step) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fa_co;
      // Counter parks at its terminal value instead of wrapping.
      if (last) begin
        cout     <= fa_co;
        overflow <= carry ^ fa_co;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  localparam logic [W-1:0] MASK = '1;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_vec  = 0;
  int n_miss = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output logic [W-1:0] rs, output logic rc,
                       output logic ro);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    bb = b;
    cc = c;
`ifdef SERIAL_SUB_EN
    if (s) begin
      bb = ~b;
      cc = 1'b1;
    end
`endif
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
    rs   = full[W-1:0];
    rc   = full[W];
    ro   = (a[W-1] == bb[W-1]) && (rs[W-1] != a[W-1]);
  endtask

  // Accepted start edge, then scramble inputs (must have no effect).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s);
    a_in  = a;
    b_in  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
    check("sum_cleared_at_load", 32'(sum), 32'h0);
  endtask

  // Wait (bounded) for done; check latency, result and the pulse width.
  task automatic finish_op(input string tag, input int already, input logic [W-1:0] es,
                           input logic ec, input logic eo, input bit hold);
    int cyc;
    cyc = already;
    while (done !== 1'b1 && cyc < 4 * W) begin
      check({tag, "_busy"}, 32'(busy), 32'h1);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(W));
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    if (hold) begin
      check({tag, "_b2b_busy"}, 32'(busy), 32'h1);
      check({tag, "_b2b_sum_clr"}, 32'(sum), 32'h0);
    end else begin
      check({tag, "_idle_busy"}, 32'(busy), 32'h0);
      check({tag, "_sum_held"}, 32'(sum), 32'(es));
    end
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rcin;
    logic         rsub;
    int           extra;

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    // Basic add.
    launch(8'h3C, 8'h42, 1'b0, 1'b0);
    finish_op("add3c42", 0, 8'h7E, 1'b0, 1'b0, 1'b0);

    // Wrap-around with carry out, then signed overflow via cin.
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    finish_op("addff01", 0, 8'h00, 1'b1, 1'b0, 1'b0);
    launch(8'h7F, 8'h00, 1'b1, 1'b0);
    finish_op("add7f_cin", 0, 8'h80, 1'b0, 1'b1, 1'b0);

    // start while busy is ignored.
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    tick();
    a_in  = 8'hAA;
    b_in  = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_op("ignore_start", 3, 8'h30, 1'b0, 1'b0, 1'b0);
    extra = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done === 1'b1) extra++;
      tick();
    end
    check("ignore_start_no_extra_done", 32'(extra), 32'h0);

    // Back-to-back with start held through DONE.
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    a_in  = 8'h01;
    b_in  = 8'h01;
    finish_op("b2b_first", 0, 8'h46, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    finish_op("b2b_second", 0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Leave cout/overflow set, then reset mid-RUN.
    launch(8'hFF, 8'h80, 1'b0, 1'b0);
    finish_op("addff80", 0, 8'h7F, 1'b1, 1'b1, 1'b0);
    launch(8'hF0, 8'h0F, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_sum", 32'(sum), 32'h0);
    check("midrst_cout", 32'(cout), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    extra = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done === 1'b1) extra++;
      tick();
    end
    check("midrst_no_done", 32'(extra), 32'h0);

    // Subtract request: honoured only in the SERIAL_SUB_EN build.
    model(8'h05, 8'h07, 1'b0, 1'b1, es, ec, eo);
`ifdef SERIAL_SUB_EN
    check("sub_model_ref", 32'(es), 32'hFE);
`else
    check("sub_model_ref", 32'(es), 32'h0C);
`endif
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    finish_op("sub0507", 0, es, ec, eo, 1'b0);

    // Randomized operations against the model.
    for (int n = 0; n < 24; n++) begin
      ra   = W'($urandom) & MASK;
      rb   = W'($urandom) & MASK;
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      model(ra, rb, rcin, rsub, es, ec, eo);
      launch(ra, rb, rcin, rsub);
      finish_op("rand", 0, es, ec, eo, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
